pe_msub_pipe: RTL and testbench

- Fully pipelined fixed-point processing element for the elimination network.
- Per operation computes P = A*B, then R = C - P, C + P, P or C, selected by mode.
- Accepts one operation per clock and reports the product and final result on separate valid-qualified outputs, each carrying a tag.
- Parametrised in width, fractional bits and both stage latencies; adds saturation, overflow flag and a global stall.

---
 rtl/pe_msub_if.sv | 34 +++
 rtl/pe_msub_pipe.sv | 166 ++++++++++++++++
 tb/tb_pe_msub_pipe.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pe_msub_if.sv
// Operation/result bundle for the pe_msub_pipe processing element.
// The master side issues operations and stall; the slave side is the PE.
interface pe_msub_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             stall;
  logic             mult_valid;
  logic [WIDTH-1:0] mult_result;
  logic [TAG_W-1:0] mult_tag;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_mode, in_tag, a, b, c, stall,
    input  mult_valid, mult_result, mult_tag,
    input  out_valid, out_result, out_tag, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_mode, in_tag, a, b, c, stall,
    output mult_valid, mult_result, mult_tag,
    output out_valid, out_result, out_tag, out_ovf, busy
  );
endinterface

// File: rtl/pe_msub_pipe.sv
// Pipelined fixed-point multiply / subtract-add processing element.
// P = sat((A*B) >>> FRAC), then R = sat(C-P) | sat(C+P) | P | C by mode.
// The product is formed combinationally at the input and carried through
// MULT_LAT register stages; synthesis register retiming is expected to pull
// those stages into the multiplier. The final stage works the same way over
// SUB_LAT stages. A global stall freezes every register, valids included.
module pe_msub_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int MULT_LAT = 3,
  parameter int SUB_LAT  = 2,
  parameter int TAG_W    = 4
) (
  input  logic     clk,
  input  logic     rst,
  pe_msub_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0]       MODE_MSUB = 2'b00;
  localparam logic [1:0]       MODE_MADD = 2'b01;
  localparam logic [1:0]       MODE_MULT = 2'b10;
  localparam logic [1:0]       MODE_PASS = 2'b11;

  // Product front end
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [2*WIDTH-1:0] prod_shr;
  logic [WIDTH:0]            prod_hi;
  logic [WIDTH-1:0]          prod_sat;
  logic                      prod_ovf;

  // Multiplier-side stages: index MULT_LAT-1 drives the mult_* outputs
  logic             m_valid_reg [0:MULT_LAT-1];
  logic [1:0]       m_mode_reg  [0:MULT_LAT-1];
  logic [TAG_W-1:0] m_tag_reg   [0:MULT_LAT-1];
  logic [WIDTH-1:0] m_c_reg     [0:MULT_LAT-1];
  logic [WIDTH-1:0] m_p_reg     [0:MULT_LAT-1];
  logic             m_ovf_reg   [0:MULT_LAT-1];

  // Final-stage combinational result
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] mc;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   sel_ext;
  logic             fin_sat;
  logic [WIDTH-1:0] fin_result;
  logic             fin_ovf;

  // Final-side stages: index SUB_LAT-1 drives the out_* outputs
  logic             s_valid_reg  [0:SUB_LAT-1];
  logic [TAG_W-1:0] s_tag_reg    [0:SUB_LAT-1];
  logic [WIDTH-1:0] s_result_reg [0:SUB_LAT-1];
  logic             s_ovf_reg    [0:SUB_LAT-1];

  logic busy_any;

  // Full-precision product, truncating shift, saturate to WIDTH bits.
  // In range only when the top WIDTH+1 bits are all copies of the sign.
  always_comb begin
    prod_full = $signed(bus.a) * $signed(bus.b);
    prod_shr  = prod_full >>> FRAC;
    prod_hi   = prod_shr[2*WIDTH-1:WIDTH-1];
    prod_ovf  = ~((&prod_hi) | ~(|prod_hi));
    prod_sat  = prod_ovf ? (prod_hi[WIDTH] ? MIN_VAL : MAX_VAL)
                         : prod_shr[WIDTH-1:0];
  end

  // Multiplier-side shift register carrying product plus aligned side data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        m_valid_reg[i] <= 1'b0;
        m_mode_reg[i]  <= '0;
        m_tag_reg[i]   <= '0;
        m_c_reg[i]     <= '0;
        m_p_reg[i]     <= '0;
        m_ovf_reg[i]   <= 1'b0;
      end
    end else if (!bus.stall) begin
      m_valid_reg[0] <= bus.in_valid;
      m_mode_reg[0]  <= bus.in_mode;
      m_tag_reg[0]   <= bus.in_tag;
      m_c_reg[0]     <= bus.c;
      m_p_reg[0]     <= prod_sat;
      m_ovf_reg[0]   <= prod_ovf;
      for (int i = 1; i < MULT_LAT; i++) begin
        m_valid_reg[i] <= m_valid_reg[i-1];
        m_mode_reg[i]  <= m_mode_reg[i-1];
        m_tag_reg[i]   <= m_tag_reg[i-1];
        m_c_reg[i]     <= m_c_reg[i-1];
        m_p_reg[i]     <= m_p_reg[i-1];
        m_ovf_reg[i]   <= m_ovf_reg[i-1];
      end
    end
  end

  // Mode-selected final result; sum/difference kept one bit wider to catch overflow
  always_comb begin
    mp         = m_p_reg[MULT_LAT-1];
    mc         = m_c_reg[MULT_LAT-1];
    add_ext    = {mc[WIDTH-1], mc} + {mp[WIDTH-1], mp};
    sub_ext    = {mc[WIDTH-1], mc} - {mp[WIDTH-1], mp};
    sel_ext    = (m_mode_reg[MULT_LAT-1] == MODE_MADD) ? add_ext : sub_ext;
    fin_sat    = sel_ext[WIDTH] ^ sel_ext[WIDTH-1];
    fin_result = mp;
    fin_ovf    = m_ovf_reg[MULT_LAT-1];
    case (m_mode_reg[MULT_LAT-1])
      MODE_MSUB, MODE_MADD: begin
        fin_result = fin_sat ? (sel_ext[WIDTH] ? MIN_VAL : MAX_VAL)
                             : sel_ext[WIDTH-1:0];
        fin_ovf    = m_ovf_reg[MULT_LAT-1] | fin_sat;
      end
      MODE_MULT: begin
        fin_result = mp;
        fin_ovf    = m_ovf_reg[MULT_LAT-1];
      end
      MODE_PASS: begin
        fin_result = mc;
        fin_ovf    = 1'b0;
      end
      default: ;
    endcase
  end

  // Final-side shift register toward the out_* ports
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SUB_LAT; i++) begin
        s_valid_reg[i]  <= 1'b0;
        s_tag_reg[i]    <= '0;
        s_result_reg[i] <= '0;
        s_ovf_reg[i]    <= 1'b0;
      end
    end else if (!bus.stall) begin
      s_valid_reg[0]  <= m_valid_reg[MULT_LAT-1];
      s_tag_reg[0]    <= m_tag_reg[MULT_LAT-1];
      s_result_reg[0] <= fin_result;
      s_ovf_reg[0]    <= fin_ovf;
      for (int i = 1; i < SUB_LAT; i++) begin
        s_valid_reg[i]  <= s_valid_reg[i-1];
        s_tag_reg[i]    <= s_tag_reg[i-1];
        s_result_reg[i] <= s_result_reg[i-1];
        s_ovf_reg[i]    <= s_ovf_reg[i-1];
      end
    end
  end

  // busy is the OR of every stage valid, so it drops right after the last delivery
  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < MULT_LAT; i++) busy_any = busy_any | m_valid_reg[i];
    for (int i = 0; i < SUB_LAT; i++)  busy_any = busy_any | s_valid_reg[i];
  end

  assign bus.mult_valid  = m_valid_reg[MULT_LAT-1];
  assign bus.mult_result = m_p_reg[MULT_LAT-1];
  assign bus.mult_tag    = m_tag_reg[MULT_LAT-1];
  assign bus.out_valid   = s_valid_reg[SUB_LAT-1];
  assign bus.out_result  = s_result_reg[SUB_LAT-1];
  assign bus.out_tag     = s_tag_reg[SUB_LAT-1];
  assign bus.out_ovf     = s_ovf_reg[SUB_LAT-1];
  assign bus.busy        = busy_any;

endmodule

// File: tb/tb_pe_msub_pipe.sv
// Directed bench for pe_msub_pipe with default parameters.
// Cycle k is the interval after clock edge k-1; inputs for cycle k are
// driven at its start and outputs visible in cycle k are sampled 1 ns in.
module tb_pe_msub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pe_msub_if #(.WIDTH(32), .TAG_W(4)) bus ();

  pe_msub_pipe #(
    .WIDTH(32), .FRAC(16), .MULT_LAT(3), .SUB_LAT(2), .TAG_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] mode, input logic [3:0] tag,
                       input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
    bus.in_valid = v;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    bus.a        = av;
    bus.b        = bv;
    bus.c        = cv;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic chk_valids(input string name, input logic em, input logic eo, input logic eb);
    chk({name, " mult_valid"}, {31'd0, bus.mult_valid}, {31'd0, em});
    chk({name, " out_valid"},  {31'd0, bus.out_valid},  {31'd0, eo});
    chk({name, " busy"},       {31'd0, bus.busy},       {31'd0, eb});
  endtask

  // One isolated operation issued in cycle 0, walked until the pipe drains
  task automatic run_op(input string name, input logic [1:0] mode, input logic [3:0] tag,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                        input logic [31:0] em, input logic [31:0] eo, input logic eovf);
    drive(1'b1, mode, tag, av, bv, cv);
    chk_valids(name, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle();
    for (int k = 1; k <= 6; k++) begin
      chk_valids(name, k == 3, k == 5, (k >= 1) && (k <= 5));
      if (k == 3) begin
        chk({name, " mult_result"}, bus.mult_result, em);
        chk({name, " mult_tag"}, {28'd0, bus.mult_tag}, {28'd0, tag});
      end
      if (k == 5) begin
        chk({name, " out_result"}, bus.out_result, eo);
        chk({name, " out_tag"}, {28'd0, bus.out_tag}, {28'd0, tag});
        chk({name, " out_ovf"}, {31'd0, bus.out_ovf}, {31'd0, eovf});
        $display("op %s tag %0d mode %0d: mult 0x%08h out 0x%08h ovf %0d",
                 name, tag, mode, bus.mult_result, bus.out_result, bus.out_ovf);
      end
      next_cycle();
    end
  endtask

  logic [31:0] stream_res [0:3];
  logic [1:0]  stream_mode [0:3];

  initial begin
    stream_res[0] = 32'h0004_0000; stream_mode[0] = 2'b00;
    stream_res[1] = 32'h0006_0000; stream_mode[1] = 2'b01;
    stream_res[2] = 32'h0001_0000; stream_mode[2] = 2'b10;
    stream_res[3] = 32'h0005_0000; stream_mode[3] = 2'b11;

    // Reset
    idle();
    bus.stall = 1'b0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    chk_valids("reset", 1'b0, 1'b0, 1'b0);
    chk("reset mult_result", bus.mult_result, 32'd0);
    chk("reset out_result", bus.out_result, 32'd0);
    chk("reset out_tag", {28'd0, bus.out_tag}, 32'd0);
    chk("reset out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    $display("reset released");

    // Single operations
    run_op("msub_basic", 2'b00, 4'd5, 32'h0002_0000, 32'h0003_0000, 32'h000A_0000,
           32'h0006_0000, 32'h0004_0000, 1'b0);
    run_op("msub_neg",   2'b00, 4'd1, 32'hFFFE_8000, 32'h0002_0000, 32'h0000_0000,
           32'hFFFD_0000, 32'h0003_0000, 1'b0);
    run_op("mult_sat_pos", 2'b10, 4'd2, 32'h7FFF_0000, 32'h0002_0000, 32'h0000_0000,
           32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    run_op("mult_sat_neg", 2'b10, 4'd3, 32'h8000_0000, 32'h0002_0000, 32'h0000_0000,
           32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op("msub_sat_fin", 2'b00, 4'd4, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000,
           32'h0001_0000, 32'h8000_0000, 1'b1);
    run_op("pass_ovf_prod", 2'b11, 4'd6, 32'h7FFF_0000, 32'h0002_0000, 32'h1234_5678,
           32'h7FFF_FFFF, 32'h1234_5678, 1'b0);
    run_op("mult_trunc", 2'b10, 4'd7, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("madd_sat_fin", 2'b01, 4'd8, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_8000,
           32'h0001_0000, 32'h7FFF_FFFF, 1'b1);

    // Back-to-back stream of all four modes
    for (int k = 0; k <= 9; k++) begin
      if (k < 4) drive(1'b1, stream_mode[k], 4'(k), 32'h0001_0000, 32'h0001_0000, 32'h0005_0000);
      else idle();
      chk_valids("stream", (k >= 3) && (k <= 6), (k >= 5) && (k <= 8), (k >= 1) && (k <= 8));
      if (k >= 3 && k <= 6) begin
        chk("stream mult_result", bus.mult_result, 32'h0001_0000);
        chk("stream mult_tag", {28'd0, bus.mult_tag}, 32'(k - 3));
      end
      if (k >= 5 && k <= 8) begin
        chk("stream out_tag", {28'd0, bus.out_tag}, 32'(k - 5));
        chk("stream out_result", bus.out_result, stream_res[k-5]);
        chk("stream out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        $display("stream tag %0d: out 0x%08h ovf %0d", bus.out_tag, bus.out_result, bus.out_ovf);
      end
      next_cycle();
    end

    // Stall in cycles 2-4 and again 8-9
    for (int k = 0; k <= 12; k++) begin
      if (k == 0) drive(1'b1, 2'b00, 4'd9, 32'h0002_0000, 32'h0003_0000, 32'h000A_0000);
      else idle();
      bus.stall = ((k >= 2) && (k <= 4)) || (k == 8) || (k == 9);
      chk_valids("stall", k == 6, (k >= 8) && (k <= 10), (k >= 1) && (k <= 10));
      if (k == 6) chk("stall mult_result", bus.mult_result, 32'h0006_0000);
      if (k >= 8 && k <= 10) begin
        chk("stall out_result", bus.out_result, 32'h0004_0000);
        chk("stall out_tag", {28'd0, bus.out_tag}, 32'd9);
        $display("stall cycle %0d: out 0x%08h tag %0d", k, bus.out_result, bus.out_tag);
      end
      next_cycle();
    end
    bus.stall = 1'b0;

    // Inputs offered while stalled are never accepted
    for (int k = 0; k <= 9; k++) begin
      if (k < 3) drive(1'b1, 2'b00, 4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      else idle();
      bus.stall = (k < 3);
      chk_valids("stall_ignore", 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    bus.stall = 1'b0;
    $display("stall_ignore: no output observed");

    // Reset while operations are in flight, then a fresh op at cycle 4
    for (int k = 0; k <= 10; k++) begin
      if (k <= 2) drive(1'b1, 2'b01, 4'(11 + k), 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      else if (k == 4) drive(1'b1, 2'b00, 4'd9, 32'h0002_0000, 32'h0003_0000, 32'h000A_0000);
      else idle();
      rst = (k == 2);
      if (k >= 3) chk_valids("rst_flight", k == 7, k == 9, (k >= 5) && (k <= 9));
      if (k == 3) begin
        chk("rst_flight mult_result", bus.mult_result, 32'd0);
        chk("rst_flight out_result", bus.out_result, 32'd0);
      end
      if (k == 9) begin
        chk("rst_flight out_result", bus.out_result, 32'h0004_0000);
        chk("rst_flight out_tag", {28'd0, bus.out_tag}, 32'd9);
        $display("rst_flight fresh op: out 0x%08h tag %0d", bus.out_result, bus.out_tag);
      end
      next_cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
